// File: rtl/piso_serializer.sv
// WIDTH-bit parallel-in/serial-out shift register with simultaneous serial-in capture,
// selectable bit order, an EN shift tick and a BUSY/DONE word handshake.
module piso_serializer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b1}},
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] PDATA,
    input  logic             SI,
    output logic             SO,
    output logic [WIDTH-1:0] PQ,
    output logic             BUSY,
    output logic             DONE,
    output logic             dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;

    // Handshake: LOAD is a request that is accepted only on an edge where BUSY=0;
    // BUSY acts as the inverse of ready, and DONE marks the first idle cycle after a word.
    assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], SI} : {SI, sreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // LOAD wins over EN; no shift happens on the load edge.
                if (LOAD) begin
                    sreg_d  = PDATA;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (EN) begin
                    sreg_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign SO        = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign PQ        = sreg_q;
    assign BUSY      = (state_q == SHIFT);
    assign DONE      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share all inputs
// and are checked against per-instance expected queues of serial bits and final words.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] pdata;
  logic       si;

  logic       so_m, busy_m, done_m, dbg_m;
  logic [7:0] pq_m;
  logic       so_l, busy_l, done_l, dbg_l;
  logic [7:0] pq_l;

  logic [0:0] so_m_q[$];
  logic [0:0] so_l_q[$];
  logic [7:0] pq_m_q[$];
  logic [7:0] pq_l_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  piso_serializer #(.WIDTH(8), .INIT(8'hFF), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .EN(en), .LOAD(load), .PDATA(pdata), .SI(si),
    .SO(so_m), .PQ(pq_m), .BUSY(busy_m), .DONE(done_m), .dbg_state(dbg_m)
  );

  piso_serializer #(.WIDTH(8), .INIT(8'hFF), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .EN(en), .LOAD(load), .PDATA(pdata), .SI(si),
    .SO(so_l), .PQ(pq_l), .BUSY(busy_l), .DONE(done_l), .dbg_state(dbg_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_so_m"}, so_m, 1);
    check({tag, "_so_l"}, so_l, 1);
    check({tag, "_pq_m"}, pq_m, 8'hFF);
    check({tag, "_pq_l"}, pq_l, 8'hFF);
    check({tag, "_busy_m"}, busy_m, 0);
    check({tag, "_busy_l"}, busy_l, 0);
    check({tag, "_done_m"}, done_m, 0);
    check({tag, "_done_l"}, done_l, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy_m", busy_m, 0);
      check("idle_busy_l", busy_l, 0);
      check("idle_done_m", done_m, 0);
      check("idle_done_l", done_l, 0);
    end
  endtask

  // Drives one word starting at the current negedge. period: EN asserted every
  // period-th cycle. busy_load_at: shift index during which LOAD 8'h00 is pulsed
  // (-1 none). abort_after: shift count at which rst is asserted (-1 none).
  task automatic run_word(input logic [7:0] data, input int period, input logic [7:0] si_bits,
                          input int busy_load_at, input int abort_after);
    int cyc;
    int shifts;
    logic [7:0] rev;
    for (int i = 0; i < 8; i++) begin
      so_m_q.push_back(data[7-i]);
      so_l_q.push_back(data[i]);
      rev[i] = si_bits[7-i];
    end
    pq_m_q.push_back(si_bits);
    pq_l_q.push_back(rev);

    load  = 1'b1;
    pdata = data;
    en    = 1'b1;
    si    = 1'b0;
    @(negedge clk);
    load = 1'b0;

    cyc    = 0;
    shifts = 0;
    while (shifts < 8 && cyc < 200) begin
      if (abort_after >= 0 && shifts == abort_after) break;
      check("shift_busy_m", busy_m, 1);
      check("shift_busy_l", busy_l, 1);
      check("shift_done_m", done_m, 0);
      check("shift_done_l", done_l, 0);
      check("so_m", so_m, so_m_q[0]);
      check("so_l", so_l, so_l_q[0]);
      en    = ((cyc % period) == period - 1);
      si    = si_bits[7-shifts];
      load  = (shifts == busy_load_at);
      pdata = (shifts == busy_load_at) ? 8'h00 : data;
      @(negedge clk);
      cyc++;
      if (en) begin
        shifts++;
        void'(so_m_q.pop_front());
        void'(so_l_q.pop_front());
      end
    end
    en   = 1'b0;
    load = 1'b0;

    if (cyc >= 200) begin
      check("word_timeout", cyc, 0);
      so_m_q.delete(); so_l_q.delete(); pq_m_q.delete(); pq_l_q.delete();
    end else if (abort_after >= 0 && shifts == abort_after) begin
      #2 rst = 1'b1;
      #1 check_reset_values("abort");
      @(negedge clk);
      check_reset_values("abort_hold");
      rst = 1'b0;
      so_m_q.delete(); so_l_q.delete(); pq_m_q.delete(); pq_l_q.delete();
      idle(3);
    end else begin
      check("done_m", done_m, 1);
      check("done_l", done_l, 1);
      check("end_busy_m", busy_m, 0);
      check("end_busy_l", busy_l, 0);
      check("word_cycles", cyc, 8 * period);
      check("pq_m", pq_m, pq_m_q.pop_front());
      check("pq_l", pq_l, pq_l_q.pop_front());
      check("so_q_empty", so_m_q.size() + so_l_q.size(), 0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    pdata = 8'h00;
    si    = 1'b0;

    // asynchronous reset asserted mid-cycle
    #3 rst = 1'b1;
    #1 check_reset_values("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_values("idle_en");
      check("dbg_m", dbg_m, 0);
      check("dbg_l", dbg_l, 0);
    end
    en = 1'b0;

    // full-rate serialization, then throttled
    run_word(8'hAB, 1, 8'h00, -1, -1);
    idle(2);
    run_word(8'hAB, 3, 8'h00, -1, -1);
    idle(2);

    // deserialization of 0,1,0,1,1,0,1,0
    run_word(8'h00, 1, 8'b0101_1010, -1, -1);
    idle(1);

    // LOAD ignored while busy, then back-to-back word from the DONE cycle
    run_word(8'hAB, 1, 8'h00, 3, -1);
    run_word(8'h3C, 1, 8'h00, -1, -1);
    idle(2);

    // random words with random throttle
    for (int w = 0; w < 4; w++) begin
      run_word(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)),
               8'($urandom_range(0, 255)), -1, -1);
      idle(1);
    end

    // reset after 4 shifts, then a normal word
    run_word(8'hAB, 1, 8'h00, -1, 4);
    run_word(8'hC5, 2, 8'hA5, -1, -1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
